// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_unit
// Description : Walks a register index range through one register-file read
//               port and streams each word out over valid/ready.
//               Optional macro REG_DUMP_CHECKSUM_EN appends a sum beat.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_unit #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_idx,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0] r_dout_idx;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              w_hs;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_cnt_inc;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    assign w_hs      = r_valid & dout_ready;
    assign w_at_end  = (r_cnt == r_end);
    // Indices past the last implemented register wrap back to zero.
    assign w_cnt_inc = (r_cnt == c_LAST_REG) ? '0 : r_cnt + c_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_SEND;
            S_SEND: begin
                if (w_hs) begin
                    if (w_at_end) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        w_next = S_CSUM;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_CSUM:  if (w_hs) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_end      <= '0;
            r_dout     <= '0;
            r_dout_idx <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt  <= first_idx;
                        r_end  <= last_idx;
                        r_busy <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_sum  <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    // rd_data is sampled here, so a same-edge write is not seen.
                    r_dout     <= rd_data;
                    r_dout_idx <= r_cnt;
                    r_valid    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    r_last     <= 1'b0;
`else
                    r_last     <= w_at_end;
`endif
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_sum   <= r_sum + r_dout;
`endif
                        if (w_at_end) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            r_dout     <= r_sum + r_dout;
                            r_dout_idx <= '0;
                            r_last     <= 1'b1;
                            r_valid    <= 1'b1;
`endif
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_hs) r_valid <= 1'b0;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rd_addr    = r_cnt;
    assign dout       = r_dout;
    assign dout_idx   = r_dout_idx;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_unit
// Description : Directed self-checking bench for reg_dump_unit with a
//               register-file model (R[k] = k*3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] dout;
    logic [4:0]  dout_idx;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        busy;
    logic        done;

    logic [31:0] regs  [32];
    logic [31:0] exp_r [32];
    logic        preload;
    logic        wr_arm;
    int          n_checks;
    int          n_err;

    reg_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_idx(first_idx), .last_idx(last_idx),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    // Pipeline write model: R[4] <= 0xDEAD lands on the edge closing FETCH of idx 4.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'(k * 3);
        end else if (wr_arm && busy && !dout_valid && rd_addr == 5'd4) begin
            regs[4] <= 32'hDEAD;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge with the DUT idle; returns on a negedge.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int stall_idx, input int stall_n,
                            input int abort_idx, input bit restart,
                            input int exp_cycles);
        logic [4:0]  e_idx;
        logic [31:0] e_sum;
        int          cyc;
        int          stalled;
        bit          fin;
        bit          aborted;
        e_idx = f; e_sum = '0; cyc = 0; stalled = 0; fin = 0; aborted = 0;
        start = 1'b1; first_idx = f; last_idx = l; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("c1_valid", {31'd0, dout_valid}, 32'd0);
        check("c1_busy", {31'd0, busy}, 32'd1);
        if (restart) begin
            start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
        end
        while (!fin && cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (dout_valid && abort_idx >= 0 && int'(dout_idx) == abort_idx) begin
                reset = 1'b1;
                fin = 1; aborted = 1;
            end else if (dout_valid && int'(dout_idx) == stall_idx && stalled < stall_n) begin
                dout_ready = 1'b0;
                check("hold_data", dout, exp_r[e_idx]);
                check("hold_idx", {27'd0, dout_idx}, {27'd0, e_idx});
                stalled++;
            end else if (dout_valid) begin
                dout_ready = 1'b1;
                check("beat_idx", {27'd0, dout_idx}, {27'd0, e_idx});
                check("beat_data", dout, exp_r[e_idx]);
`ifdef REG_DUMP_CHECKSUM_EN
                check("beat_last", {31'd0, dout_last}, 32'd0);
`else
                check("beat_last", {31'd0, dout_last}, {31'd0, (e_idx == l)});
`endif
                e_sum = e_sum + exp_r[e_idx];
                if (e_idx == l) fin = 1;
                else e_idx = e_idx + 5'd1;
            end else if (stalled > 0 && stalled < stall_n) begin
                check("stall_valid", {31'd0, dout_valid}, 32'd1);
            end
        end
        if (!fin) check("timeout", 32'd1, 32'd0);
        if (exp_cycles >= 0) check("beat_cycles", 32'(cyc), 32'(exp_cycles));
        if (!aborted) begin
`ifdef REG_DUMP_CHECKSUM_EN
            @(negedge clk);
            check("csum_valid", {31'd0, dout_valid}, 32'd1);
            check("csum_data", dout, e_sum);
            check("csum_idx", {27'd0, dout_idx}, 32'd0);
            check("csum_last", {31'd0, dout_last}, 32'd1);
`endif
            @(negedge clk);
            check("pre_done", {31'd0, done}, 32'd0);
            check("pre_done_busy", {31'd0, busy}, 32'd1);
            check("pre_done_valid", {31'd0, dout_valid}, 32'd0);
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("done_end", {31'd0, done}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_valid", {31'd0, dout_valid}, 32'd0);
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; first_idx = '0; last_idx = '0;
        dout_ready = 1'b1; preload = 1'b1; wr_arm = 1'b0;
        for (int k = 0; k < 32; k++) exp_r[k] = 32'(k * 3);
        repeat (3) @(negedge clk);
        reset = 1'b0; preload = 1'b0;
        check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_idx", {27'd0, dout_idx}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_last", {31'd0, dout_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);

        run_dump(5'd0, 5'd31, -1, 0, -1, 1'b0, 63);   // full dump, 2 cycles/word
        run_dump(5'd30, 5'd1, -1, 0, -1, 1'b0, 7);    // wrap-around
        run_dump(5'd5, 5'd5, -1, 0, -1, 1'b1, 1);     // single beat, restart ignored
        run_dump(5'd0, 5'd7, 3, 7, -1, 1'b0, -1);     // backpressure on idx 3

        run_dump(5'd0, 5'd31, -1, 0, 10, 1'b0, -1);   // reset in SEND at idx 10
        @(negedge clk);
        check("abort_rd_addr", {27'd0, rd_addr}, 32'd0);
        check("abort_dout", dout, 32'd0);
        check("abort_idx", {27'd0, dout_idx}, 32'd0);
        check("abort_valid", {31'd0, dout_valid}, 32'd0);
        check("abort_last", {31'd0, dout_last}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0; dout_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_dump(5'd6, 5'd9, -1, 0, -1, 1'b0, 7);     // normal after reset

        wr_arm = 1'b1;
        run_dump(5'd2, 5'd6, -1, 0, -1, 1'b0, 9);     // idx 4 fetched pre-write
        wr_arm = 1'b0;
        exp_r[4] = 32'hDEAD;
        run_dump(5'd2, 5'd6, -1, 0, -1, 1'b0, 9);     // now sees 0xDEAD

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
